// File: rtl/conv_buf_rd_ctrl.sv
// -----------------------------------------------------------------------------
// conv_buf_rd_ctrl
//
// Read-side controller for the conv line/weight buffer. The buffer is a
// single-clock simple dual-port RAM with no output register: it latches
// rd_addr on a clock edge where rd_clk_en is high and presents the word on
// rd_data right after that edge, holding it while rd_clk_en stays low.
//
// A command describes a 2-D region (base address, words per row, rows, and the
// address step between row starts). The controller walks the region in
// row-major order and streams one word per cycle to the MAC array with a
// valid/ready handshake. Back-pressure is applied by dropping rd_clk_en, so
// the RAM output latch itself holds the stalled word; no skid buffer is used.
//
// Ports
//   rd_clk       single clock, RAM read clock is tied to it
//   rd_rst_n     synchronous reset, active low
//   cmd_valid    command request
//   cmd_ready    high while idle; command accepted on cmd_valid & cmd_ready
//   cmd_base     address of element (0,0)
//   cmd_cols     words per row (0 makes the command empty)
//   cmd_rows     number of rows (0 makes the command empty)
//   cmd_stride   address step between row starts
//   ram_rd_addr  RAM read address
//   ram_rd_ce    RAM read clock enable
//   ram_rd_data  RAM read data (valid the cycle after the capture edge)
//   m_valid      output word valid
//   m_ready      downstream accepts the word
//   m_data       output word (straight from the RAM)
//   m_eol        word is the last of its row
//   m_last       word is the last of the command
//   busy         controller not idle
//   done         one-cycle pulse when a command completes
// -----------------------------------------------------------------------------
module conv_buf_rd_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8,
  parameter int DIM_W  = 9
) (
  input  logic              rd_clk,
  input  logic              rd_rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [DIM_W-1:0]  cmd_cols,
  input  logic [DIM_W-1:0]  cmd_rows,
  input  logic [ADDR_W-1:0] cmd_stride,
  output logic [ADDR_W-1:0] ram_rd_addr,
  output logic              ram_rd_ce,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_eol,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  // Latched command fields
  logic [DIM_W-1:0]  r_cols;
  logic [DIM_W-1:0]  r_rows;
  logic [ADDR_W-1:0] r_stride;

  // Walk position inside the region
  logic [DIM_W-1:0]  r_col;
  logic [DIM_W-1:0]  r_row;
  logic [ADDR_W-1:0] r_row_base;

  // Output beat flags
  logic              r_valid;
  logic              r_eol;
  logic              r_last;
  logic              r_done;

  // Control strobes from the next-state logic
  logic              w_adv;
  logic              w_cmd_acc;
  logic              w_cmd_empty;
  logic              w_col_end;
  logic              w_row_end;
  logic              w_load;
  logic              w_issue;
  logic              w_retire;
  logic              w_done_nxt;

  // The output slot can take a new word when it is empty or being drained.
  // The RAM is clocked on exactly those edges, so a stalled word stays in
  // the RAM output latch untouched.
  assign w_adv       = !r_valid || m_ready;
  assign ram_rd_ce   = w_adv;

  // Address is presented combinationally from the walk registers; the RAM
  // latches it on the next enabled edge, which is the same edge that raises
  // m_valid, so data and flags line up. Sum wraps modulo 2**ADDR_W.
  assign ram_rd_addr = r_row_base + ADDR_W'(r_col);

  assign w_cmd_acc   = cmd_valid && (r_state == ST_IDLE);
  assign w_cmd_empty = (cmd_cols == {DIM_W{1'b0}}) || (cmd_rows == {DIM_W{1'b0}});
  assign w_col_end   = (r_col == (r_cols - DIM_W'(1)));
  assign w_row_end   = (r_row == (r_rows - DIM_W'(1)));

  assign cmd_ready   = (r_state == ST_IDLE);
  assign busy        = (r_state != ST_IDLE);
  assign m_valid     = r_valid;
  assign m_data      = ram_rd_data;
  assign m_eol       = r_eol;
  assign m_last      = r_last;
  assign done        = r_done;

  // State register
  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_issue     = 1'b0;
    w_retire    = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cmd_acc) begin
          w_load = 1'b1;
          if (w_cmd_empty) begin
            // Nothing to read: finish immediately, stay idle.
            w_done_nxt  = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_adv) begin
          w_issue = 1'b1;
          if (w_col_end && w_row_end) begin
            w_state_nxt = ST_DRAIN;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (w_adv) begin
          w_retire = 1'b1;
          // The final beat is in the slot here, so an advance means it was
          // accepted; the explicit test keeps the exit tied to the handshake.
          if (r_valid && m_ready && r_last) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_DRAIN;
          end
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Command latch, region walk counters and output beat flags
  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      r_cols     <= {DIM_W{1'b0}};
      r_rows     <= {DIM_W{1'b0}};
      r_stride   <= {ADDR_W{1'b0}};
      r_col      <= {DIM_W{1'b0}};
      r_row      <= {DIM_W{1'b0}};
      r_row_base <= {ADDR_W{1'b0}};
      r_valid    <= 1'b0;
      r_eol      <= 1'b0;
      r_last     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
      if (w_load) begin
        r_cols     <= cmd_cols;
        r_rows     <= cmd_rows;
        r_stride   <= cmd_stride;
        r_col      <= {DIM_W{1'b0}};
        r_row      <= {DIM_W{1'b0}};
        r_row_base <= cmd_base;
      end else if (w_issue) begin
        r_valid <= 1'b1;
        r_eol   <= w_col_end;
        r_last  <= w_col_end && w_row_end;
        if (w_col_end) begin
          r_col      <= {DIM_W{1'b0}};
          r_row      <= r_row + DIM_W'(1);
          r_row_base <= r_row_base + r_stride;
        end else begin
          r_col <= r_col + DIM_W'(1);
        end
      end else if (w_retire) begin
        r_valid <= 1'b0;
        r_eol   <= 1'b0;
        r_last  <= 1'b0;
      end else begin
        r_valid <= r_valid;
      end
    end
  end

endmodule

// File: tb/tb_conv_buf_rd_ctrl.sv
module tb_conv_buf_rd_ctrl;

  logic       rd_clk;
  logic       rd_rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [8:0] cmd_base;
  logic [8:0] cmd_cols;
  logic [8:0] cmd_rows;
  logic [8:0] cmd_stride;
  logic [8:0] ram_rd_addr;
  logic       ram_rd_ce;
  logic [7:0] ram_rd_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_eol;
  logic       m_last;
  logic       busy;
  logic       done;

  int n_tests;
  int n_fail;

  logic [7:0] mem [0:511];
  logic [8:0] lat_addr;

  conv_buf_rd_ctrl #(.ADDR_W(9), .DATA_W(8), .DIM_W(9)) dut (
    .rd_clk      (rd_clk),
    .rd_rst_n    (rd_rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_base    (cmd_base),
    .cmd_cols    (cmd_cols),
    .cmd_rows    (cmd_rows),
    .cmd_stride  (cmd_stride),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_ce   (ram_rd_ce),
    .ram_rd_data (ram_rd_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_eol       (m_eol),
    .m_last      (m_last),
    .busy        (busy),
    .done        (done)
  );

  initial rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  // Buffer RAM: address latched on enabled edges, no output register.
  always @(posedge rd_clk) begin
    if (ram_rd_ce === 1'b1) begin
      ram_rd_data <= mem[ram_rd_addr];
      lat_addr    <= ram_rd_addr;
    end
  end

  function automatic logic pick_ready(input int mode, input int k);
    if (mode == 0) return 1'b1;
    if (mode == 1) return ((k % 3) == 0);
    return ($urandom_range(0, 99) < 60);
  endfunction

  // Issue one command and follow it to completion, checking every cycle
  // against a row-major walk of the region.
  task automatic run_cmd(input int base, input int cols, input int rows,
                         input int stride, input int mode, input string name);
    int q_addr[$];
    bit q_eol[$];
    bit q_last[$];
    int total, k, got, limit;
    bit finished, prev_stall;
    logic [7:0] prev_data;
    logic prev_eol, prev_last;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        q_addr.push_back((base + r * stride + c) % 512);
        q_eol.push_back(c == cols - 1);
        q_last.push_back((c == cols - 1) && (r == rows - 1));
      end
    end
    total = cols * rows;
    limit = total * 8 + 20;
    n_tests++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s cmd_ready before issue: got %b want 1", name, cmd_ready);
    end
    cmd_valid  = 1'b1;
    cmd_base   = 9'(base);
    cmd_cols   = 9'(cols);
    cmd_rows   = 9'(rows);
    cmd_stride = 9'(stride);
    m_ready    = pick_ready(mode, 0);
    @(posedge rd_clk); #1;
    cmd_valid  = 1'b0;
    cmd_base   = 9'($urandom);
    cmd_cols   = 9'($urandom);
    cmd_rows   = 9'($urandom);
    cmd_stride = 9'($urandom);
    k = 0; got = 0; finished = 0; prev_stall = 0;
    prev_data = 8'd0; prev_eol = 1'b0; prev_last = 1'b0;
    while (!finished && k < limit) begin
      if (k > 0) m_ready = pick_ready(mode, k);
      @(negedge rd_clk);
      n_tests++;
      if (ram_rd_ce !== (!m_valid || m_ready)) begin
        n_fail++;
        $display("FAIL %s ram_rd_ce k=%0d: got %b valid=%b ready=%b", name, k, ram_rd_ce, m_valid, m_ready);
      end
      if (got == total) begin
        n_tests++;
        if (done !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1 || m_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL %s completion k=%0d: done=%b busy=%b cmd_ready=%b m_valid=%b want 1 0 1 0",
                   name, k, done, busy, cmd_ready, m_valid);
        end
        finished = 1;
      end else begin
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL %s running k=%0d: done=%b busy=%b cmd_ready=%b want 0 1 0", name, k, done, busy, cmd_ready);
        end
        if (k == 0) begin
          n_tests++;
          if (m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s latency k=0: m_valid got %b want 0", name, m_valid);
          end
        end else if (mode == 0) begin
          n_tests++;
          if (m_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s full rate k=%0d: m_valid got %b want 1", name, k, m_valid);
          end
        end
        if (prev_stall) begin
          n_tests++;
          if (m_valid !== 1'b1 || m_data !== prev_data || m_eol !== prev_eol || m_last !== prev_last) begin
            n_fail++;
            $display("FAIL %s stall hold k=%0d: got v=%b d=%h e=%b l=%b want v=1 d=%h e=%b l=%b",
                     name, k, m_valid, m_data, m_eol, m_last, prev_data, prev_eol, prev_last);
          end
        end
        prev_stall = (m_valid === 1'b1) && !m_ready;
        prev_data  = m_data;
        prev_eol   = m_eol;
        prev_last  = m_last;
        if (m_valid === 1'b1 && m_ready) begin
          n_tests++;
          if (lat_addr !== 9'(q_addr[got]) || m_data !== mem[q_addr[got]] ||
              m_eol !== q_eol[got] || m_last !== q_last[got]) begin
            n_fail++;
            $display("FAIL %s beat %0d: addr=%0d data=%h eol=%b last=%b want addr=%0d data=%h eol=%b last=%b",
                     name, got, lat_addr, m_data, m_eol, m_last,
                     q_addr[got], mem[q_addr[got]], q_eol[got], q_last[got]);
          end
          got++;
        end
      end
      @(posedge rd_clk); #1;
      k++;
    end
    if (!finished) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s timeout: got %0d beats want %0d", name, got, total);
    end else begin
      m_ready = 1'b1;
      @(negedge rd_clk);
      n_tests++;
      if (done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s done pulse width: got %b want 0", name, done);
      end
      @(posedge rd_clk); #1;
    end
  endtask

  task automatic test_reset();
    rd_rst_n = 1'b0;
    repeat (2) @(posedge rd_clk);
    #1;
    rd_rst_n = 1'b1;
    @(negedge rd_clk);
    n_tests++;
    if (m_valid !== 1'b0 || m_eol !== 1'b0 || m_last !== 1'b0 || done !== 1'b0 ||
        busy !== 1'b0 || cmd_ready !== 1'b1 || ram_rd_addr !== 9'd0) begin
      n_fail++;
      $display("FAIL reset state: v=%b e=%b l=%b done=%b busy=%b rdy=%b addr=%0d want 0 0 0 0 0 1 0",
               m_valid, m_eol, m_last, done, busy, cmd_ready, ram_rd_addr);
    end
    @(posedge rd_clk); #1;
  endtask

  task automatic test_basic();
    run_cmd(0, 3, 2, 3, 0, "basic");
  endtask

  task automatic test_stall();
    run_cmd(0, 3, 2, 3, 1, "stall");
  endtask

  task automatic test_wrap();
    run_cmd(510, 4, 1, 0, 0, "wrap");
    run_cmd(500, 3, 3, 6, 2, "wrap_rows");
  endtask

  task automatic test_stride();
    run_cmd(8, 2, 3, 16, 0, "stride");
  endtask

  task automatic test_empty();
    run_cmd(17, 0, 5, 4, 0, "empty_cols");
    run_cmd(33, 3, 0, 4, 2, "empty_rows");
  endtask

  task automatic test_reset_mid();
    int got;
    cmd_valid  = 1'b1;
    cmd_base   = 9'd100;
    cmd_cols   = 9'd10;
    cmd_rows   = 9'd1;
    cmd_stride = 9'd0;
    m_ready    = 1'b1;
    @(posedge rd_clk); #1;
    cmd_valid = 1'b0;
    got = 0;
    for (int k = 0; k < 20 && got < 3; k++) begin
      @(negedge rd_clk);
      if (m_valid === 1'b1) got++;
      if (got < 3) begin
        @(posedge rd_clk); #1;
      end
    end
    rd_rst_n = 1'b0;
    @(posedge rd_clk); #1;
    rd_rst_n = 1'b1;
    @(negedge rd_clk);
    n_tests++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid after reset: v=%b busy=%b rdy=%b done=%b want 0 0 1 0",
               m_valid, busy, cmd_ready, done);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge rd_clk);
      n_tests++;
      if (m_valid !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid quiet k=%0d: v=%b done=%b want 0 0", k, m_valid, done);
      end
    end
    @(posedge rd_clk); #1;
    run_cmd(200, 3, 2, 50, 2, "after_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      run_cmd($urandom_range(0, 511), $urandom_range(1, 6), $urandom_range(1, 5),
              $urandom_range(0, 511), 2, "random");
    end
  endtask

  task automatic test_back_to_back();
    run_cmd(40, 5, 1, 0, 0, "b2b_a");
    run_cmd(300, 2, 2, 257, 0, "b2b_b");
    run_cmd(7, 1, 4, 128, 1, "b2b_c");
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rd_rst_n   = 1'b0;
    cmd_valid  = 1'b0;
    cmd_base   = 9'd0;
    cmd_cols   = 9'd0;
    cmd_rows   = 9'd0;
    cmd_stride = 9'd0;
    m_ready    = 1'b0;
    for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_stride();
    test_empty();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
